execute_muldiv: RTL and testbench

Iterative multiply/divide execution unit for the RISC-V pipeline's EXE stage. It implements the full RV M-extension (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) at a parametrised data width. While an operation is in flight it stalls the EXE stage, and it returns its result through a valid/ready handshake toward MEM. Operands arrive already forwarded, after the EXE operand muxes; the unit runs alongside the single-cycle ALU.

---
 rtl/execute_muldiv.sv | 124 ++++++++++++
 tb/tb_execute_muldiv.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_muldiv.sv
// Iterative RV M-extension unit: radix-2 shift-add multiply and restoring divide
// on operand magnitudes, with sign fix-up and a valid/ready result handoff.
module execute_muldiv #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_in,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [RD_W-1:0] rd_in,
    input  logic            flush,
    input  logic            result_ready,
    output logic            result_valid,
    output logic [XLEN-1:0] result,
    output logic [RD_W-1:0] rd_out,
    output logic            busy,
    output logic            stall_out
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t r_state, w_next;

    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_hi, r_lo, r_op;
    logic [2:0]      r_f3;
    logic            r_neg, r_neg_a;

    logic            w_is_div, w_a_signed, w_b_signed, w_sa, w_sb;
    logic            w_div0, w_ovf, w_special, w_accept;
    logic [XLEN-1:0] w_mag_a, w_mag_b, w_spec_res, w_quo, w_rem, w_fix_res;
    logic [XLEN:0]   w_sum, w_trial;
    logic [2*XLEN-1:0] w_prod;

    assign w_is_div   = funct3[2];
    assign w_a_signed = (funct3 == 3'b001) | (funct3 == 3'b010) | (funct3[2] & ~funct3[0]);
    assign w_b_signed = (funct3 == 3'b001) | (funct3[2] & ~funct3[0]);
    assign w_sa       = w_a_signed & rs1_data[XLEN-1];
    assign w_sb       = w_b_signed & rs2_data[XLEN-1];
    assign w_mag_a    = w_sa ? -rs1_data : rs1_data;
    assign w_mag_b    = w_sb ? -rs2_data : rs2_data;

    // Division corner cases bypass the iteration entirely
    assign w_div0     = w_is_div & (rs2_data == '0);
    assign w_ovf      = w_is_div & ~funct3[0] & (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) & (&rs2_data);
    assign w_special  = w_div0 | w_ovf;
    assign w_spec_res = w_div0 ? (funct3[1] ? rs1_data : '1) : (funct3[1] ? '0 : rs1_data);
    assign w_accept   = valid_in & ~flush & (r_state == IDLE);

    // Multiply: {r_hi,r_lo} is the partial product with the multiplier shifting out of r_lo.
    // Divide: r_hi is the partial remainder, r_lo shifts dividend out and quotient in.
    assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_op} : '0);
    assign w_trial = {r_hi, r_lo[XLEN-1]} - {1'b0, r_op};

    assign w_prod    = r_neg ? -{r_hi, r_lo} : {r_hi, r_lo};
    assign w_quo     = r_neg ? -r_lo : r_lo;
    assign w_rem     = r_neg_a ? -r_hi : r_hi;
    assign w_fix_res = r_f3[2] ? (r_f3[1] ? w_rem : w_quo)
                     : ((r_f3[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE: if (valid_in) w_next = w_special ? DONE : CALC;
                CALC: if (r_cnt == '0) w_next = FIX;
                FIX:  w_next = DONE;
                DONE: if (result_ready) w_next = IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    always_comb begin
        result_valid = (r_state == DONE);
        busy         = (r_state != IDLE);
        stall_out    = (valid_in | busy) & ~((r_state == DONE) & result_ready) & ~flush;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_op    <= '0;
            r_f3    <= '0;
            r_neg   <= 1'b0;
            r_neg_a <= 1'b0;
            result  <= '0;
            rd_out  <= '0;
        end else if (w_accept) begin
            r_f3    <= funct3;
            rd_out  <= rd_in;
            r_cnt   <= CW'(XLEN-1);
            r_neg   <= w_sa ^ w_sb;
            r_neg_a <= w_sa;
            r_hi    <= '0;
            r_op    <= w_is_div ? w_mag_b : w_mag_a;
            r_lo    <= w_is_div ? w_mag_a : w_mag_b;
            if (w_special) result <= w_spec_res;
        end else if (r_state == CALC && !flush) begin
            r_cnt <= r_cnt - CW'(1);
            if (r_f3[2]) begin
                r_hi <= w_trial[XLEN] ? {r_hi[XLEN-2:0], r_lo[XLEN-1]} : w_trial[XLEN-1:0];
                r_lo <= {r_lo[XLEN-2:0], ~w_trial[XLEN]};
            end else begin
                r_hi <= w_sum[XLEN:1];
                r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
            end
        end else if (r_state == FIX && !flush) begin
            result <= w_fix_res;
        end
    end
endmodule

// File: tb/tb_execute_muldiv.sv
// Randomised and directed checks of execute_muldiv against an arithmetic reference model.
module tb_execute_muldiv;
    localparam int XLEN = 32;
    localparam int RD_W = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            valid_in, flush, result_ready;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic [RD_W-1:0] rd_in;
    logic            result_valid, busy, stall_out;
    logic [XLEN-1:0] result;
    logic [RD_W-1:0] rd_out;

    int checks = 0;
    int failures = 0;

    execute_muldiv #(.XLEN(XLEN), .RD_W(RD_W)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .funct3(funct3),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_in(rd_in), .flush(flush),
        .result_ready(result_ready), .result_valid(result_valid), .result(result),
        .rd_out(rd_out), .busy(busy), .stall_out(stall_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        up = {32'b0, a} * {32'b0, b};
        case (f)
            3'd0: return up[31:0];
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
            3'd3: return up[63:32];
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Issues one op from posedge+1, returns result once valid and completes the handoff.
    // lat counts edges after the accept edge; sc counts stalled cycles in that window.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output logic [31:0] res, output logic [4:0] rdo,
                          output int lat, output int sc);
        funct3 = f; rs1_data = a; rs2_data = b; rd_in = rd;
        valid_in = 1'b1; result_ready = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0; lat = 0; sc = 0;
        while (!result_valid && lat < 100) begin
            if (stall_out) sc++;
            @(posedge clk); #1;
            lat++;
        end
        res = result; rdo = rd_out;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        checks++;
        if (result_valid !== 1'b0 || result !== '0 || rd_out !== '0 || busy !== 1'b0 || stall_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: valid=%b result=%h rd=%0d busy=%b stall=%b, want all zero",
                     result_valid, result, rd_out, busy, stall_out);
        end
        valid_in = 1'b1; #1;
        checks++;
        if (stall_out !== 1'b1) begin
            failures++;
            $display("FAIL reset_stall_follows_valid: stall=%b want 1", stall_out);
        end
        valid_in = 1'b0;
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mul_basic();
        logic [31:0] res; logic [4:0] rdo; int lat, sc;
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd9, res, rdo, lat, sc);
        checks++;
        if (res !== 32'hFFFF_FFEB || rdo !== 5'd9) begin
            failures++;
            $display("FAIL mul_basic: result=%h rd=%0d want ffffffeb rd=9", res, rdo);
        end
        checks++;
        if (lat !== 33 || sc !== 33) begin
            failures++;
            $display("FAIL mul_latency: lat=%0d stall=%0d want 33/33", lat, sc);
        end
    endtask

    task automatic test_high_mul();
        logic [2:0]  f[3]  = '{3'd1, 3'd3, 3'd2};
        logic [31:0] a[3]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] b[3]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd2};
        logic [31:0] ex[3] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        logic [31:0] res; logic [4:0] rdo; int lat, sc;
        for (int i = 0; i < 3; i++) begin
            run_op(f[i], a[i], b[i], 5'(i + 1), res, rdo, lat, sc);
            checks++;
            if (res !== ex[i] || lat !== 33) begin
                failures++;
                $display("FAIL high_mul[%0d]: result=%h lat=%0d want %h lat=33", i, res, lat, ex[i]);
            end
        end
    endtask

    task automatic test_div_special();
        logic [2:0]  f[4]  = '{3'd4, 3'd6, 3'd4, 3'd6};
        logic [31:0] a[4]  = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] b[4]  = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] ex[4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        logic [31:0] res; logic [4:0] rdo; int lat, sc;
        for (int i = 0; i < 4; i++) begin
            run_op(f[i], a[i], b[i], 5'(i + 10), res, rdo, lat, sc);
            checks++;
            if (res !== ex[i] || rdo !== 5'(i + 10) || lat !== 0) begin
                failures++;
                $display("FAIL div_special[%0d]: result=%h rd=%0d lat=%0d want %h rd=%0d lat=0",
                         i, res, rdo, lat, ex[i], i + 10);
            end
        end
    endtask

    task automatic test_div_signs();
        logic [31:0] res; logic [4:0] rdo; int lat, sc;
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd3, res, rdo, lat, sc);
        checks++;
        if (res !== 32'hFFFF_FFFF || lat !== 33) begin
            failures++;
            $display("FAIL rem_neg: result=%h lat=%0d want ffffffff lat=33", res, lat);
        end
        run_op(3'd5, 32'd100, 32'd7, 5'd4, res, rdo, lat, sc);
        checks++;
        if (res !== 32'd14 || lat !== 33) begin
            failures++;
            $display("FAIL divu: result=%h lat=%0d want e lat=33", res, lat);
        end
    endtask

    task automatic test_random();
        logic [31:0] pool[4] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1};
        logic [31:0] a, b, res, ex; logic [2:0] f; logic [4:0] rd, rdo; int lat, sc, exl;
        for (int i = 0; i < 40; i++) begin
            f  = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 3)] : $urandom;
            b  = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 3)] : $urandom;
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(1, 30);
            rd = 5'($urandom);
            ex  = model(f, a, b);
            exl = is_special(f, a, b) ? 0 : 33;
            run_op(f, a, b, rd, res, rdo, lat, sc);
            checks++;
            if (res !== ex || rdo !== rd || lat !== exl) begin
                failures++;
                $display("FAIL random[%0d] f=%0d a=%h b=%h: result=%h rd=%0d lat=%0d want %h rd=%0d lat=%0d",
                         i, f, a, b, res, rdo, lat, ex, rd, exl);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a, b, ex; int n;
        a = $urandom; b = $urandom; ex = model(3'd1, a, b);
        funct3 = 3'd1; rs1_data = a; rs2_data = b; rd_in = 5'd17;
        valid_in = 1'b1; result_ready = 1'b0;
        @(posedge clk); #1;
        valid_in = 1'b0; n = 0;
        while (!result_valid && n < 100) begin @(posedge clk); #1; n++; end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (result_valid !== 1'b1 || result !== ex || rd_out !== 5'd17 || stall_out !== 1'b1) begin
                failures++;
                $display("FAIL backpressure_hold[%0d]: valid=%b result=%h rd=%0d stall=%b want 1 %h 17 1",
                         i, result_valid, result, rd_out, stall_out, ex);
            end
            @(posedge clk); #1;
        end
        result_ready = 1'b1; #1;
        checks++;
        if (stall_out !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_release_stall: stall=%b want 0", stall_out);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_idle: busy=%b valid=%b want 0 0", busy, result_valid);
        end
    endtask

    task automatic test_flush();
        logic [31:0] res; logic [4:0] rdo; int lat, sc; bit seen;
        funct3 = 3'd5; rs1_data = $urandom; rs2_data = 32'd12345; rd_in = 5'd6;
        valid_in = 1'b1; result_ready = 1'b1;
        @(posedge clk); #1;
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1; #1;
        checks++;
        if (stall_out !== 1'b0) begin
            failures++;
            $display("FAIL flush_stall: stall=%b want 0", stall_out);
        end
        @(posedge clk); #1;
        flush = 1'b0; valid_in = 1'b0;
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_idle: busy=%b valid=%b want 0 0", busy, result_valid);
        end
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (result_valid) seen = 1'b1; end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL flush_no_result: result_valid seen=%b want 0", seen);
        end
        run_op(3'd5, 32'd9, 32'd3, 5'd8, res, rdo, lat, sc);
        checks++;
        if (res !== 32'd3 || rdo !== 5'd8 || lat !== 33) begin
            failures++;
            $display("FAIL flush_followup: result=%h rd=%0d lat=%0d want 3 rd=8 lat=33", res, rdo, lat);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] res; logic [4:0] rdo; int lat, sc;
        funct3 = 3'd0; rs1_data = $urandom; rs2_data = $urandom; rd_in = 5'd21;
        valid_in = 1'b1; result_ready = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (result_valid !== 1'b0 || result !== '0 || rd_out !== '0 || busy !== 1'b0 || stall_out !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: valid=%b result=%h rd=%0d busy=%b stall=%b want all zero",
                     result_valid, result, rd_out, busy, stall_out);
        end
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        run_op(3'd0, 32'd6, 32'd7, 5'd2, res, rdo, lat, sc);
        checks++;
        if (res !== 32'd42 || rdo !== 5'd2 || lat !== 33) begin
            failures++;
            $display("FAIL post_reset_mul: result=%h rd=%0d lat=%0d want 2a rd=2 lat=33", res, rdo, lat);
        end
    endtask

    initial begin
        rst = 1'b0; valid_in = 1'b0; flush = 1'b0; result_ready = 1'b0;
        funct3 = '0; rs1_data = '0; rs2_data = '0; rd_in = '0;
        #12;
        test_reset();
        test_mul_basic();
        test_high_mul();
        test_div_special();
        test_div_signs();
        test_backpressure();
        test_flush();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
